// File: rtl/row_clear_scanner_if.sv
// Purpose : bus bundle between the piece-loading logic and row_clear_scanner.
// Signals : start       - lock pulse requesting one scan pass
//           PixelMapIn  - board snapshot, row 0 top, row ROWS-1 bottom
//           PixelMapOut - board after clearing, valid while done or idle
//           busy        - scanner is in a pass
//           done        - one-cycle end-of-pass pulse
//           lines_pass  - rows cleared in the last pass (saturating)
//           lines_total - rows cleared since reset (saturating)
interface row_clear_scanner_if #(
   parameter int unsigned ROWS = 20,
   parameter int unsigned COLS = 10,
   parameter int unsigned CW   = 4
);
   logic                                start;
   logic [ROWS-1:0][COLS-1:0][CW-1:0]   PixelMapIn;
   logic [ROWS-1:0][COLS-1:0][CW-1:0]   PixelMapOut;
   logic                                busy;
   logic                                done;
   logic [2:0]                          lines_pass;
   logic [15:0]                         lines_total;

   // Requester side
   modport master (
      output start, PixelMapIn,
      input  PixelMapOut, busy, done, lines_pass, lines_total
   );

   // Scanner side
   modport slave (
      input  start, PixelMapIn,
      output PixelMapOut, busy, done, lines_pass, lines_total
   );
endinterface

// File: rtl/row_clear_scanner.sv
// Purpose : scans a captured board bottom-up, removes every full row by
//           shifting the rows above it down one place, and reports the
//           cleaned board together with pass and lifetime clear counts.
// Ports   : Clk   - system clock, rising edge
//           Reset - synchronous active-high reset
//           bus   - row_clear_scanner_if slave modport (start, PixelMapIn,
//                   PixelMapOut, busy, done, lines_pass, lines_total)
module row_clear_scanner #(
   parameter int unsigned ROWS = 20,
   parameter int unsigned COLS = 10,
   parameter int unsigned CW   = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   row_clear_scanner_if.slave  bus
);

   localparam int unsigned RW  = $clog2(ROWS);
   localparam int unsigned LPW = 3;
   localparam int unsigned LTW = 16;

   typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   r_q, r_d;
   map_t            map_q, map_d;
   map_t            out_q;
   logic [LPW-1:0]  lp_q, lp_d;
   logic [LTW-1:0]  lt_q, lt_d;
   logic            busy_q;
   logic            done_q;
   logic            row_full_c;

   // Row r of the working map is full when no cell holds the empty code
   always_comb begin
      row_full_c = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (map_q[r_q][c] == CW'(0)) row_full_c = 1'b0;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      map_d   = map_q;
      lp_d    = lp_q;
      lt_d    = lt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            map_d   = bus.PixelMapIn;
            r_d     = RW'(ROWS - 1);
            lp_d    = '0;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (row_full_c) begin
               state_d = S_SHIFT;
            end else if (r_q == '0) begin
               state_d = S_DONE;
            end else begin
               r_d = r_q - RW'(1);
            end
         end
         S_SHIFT: begin
            // Rows 1..r take the row above; rows below r keep their contents
            for (int i = 1; i < ROWS; i++) begin
               if (RW'(i) <= r_q) map_d[i] = map_q[i-1];
            end
            map_d[0] = '0;
            lp_d     = (lp_q == '1) ? lp_q : lp_q + LPW'(1);
            lt_d     = (lt_q == '1) ? lt_q : lt_q + LTW'(1);
            // r stays put: the row shifted into r must be tested too
            state_d  = S_CHECK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; status flags follow the next state so they
   // line up with the state they describe
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         map_q   <= '0;
         out_q   <= '0;
         lp_q    <= '0;
         lt_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         map_q   <= map_d;
         lp_q    <= lp_d;
         lt_q    <= lt_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
         if (state_d == S_DONE) out_q <= map_d;
      end
   end

   assign bus.PixelMapOut = out_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.lines_pass  = lp_q;
   assign bus.lines_total = lt_q;

endmodule

// File: tb/tb_row_clear_scanner.sv
// Purpose : self-checking bench for row_clear_scanner. A pass-level model
//           (remove full rows, compact the rest downwards, latency from the
//           clear count) is checked against the DUT on every cycle, with
//           directed passes pinning hand-computed results.
module tb_row_clear_scanner;

   localparam int unsigned ROWS = 20;
   localparam int unsigned COLS = 10;
   localparam int unsigned CW   = 4;

   typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] map_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   always #5 Clk = ~Clk;

   row_clear_scanner_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();

   row_clear_scanner #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_map(input string nm, input map_t got, input map_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit row_is_full(input map_t m, input int r);
      for (int c = 0; c < COLS; c++) if (m[r][c] == '0) return 1'b0;
      return 1'b1;
   endfunction

   // Result of a pass: drop full rows, stack survivors at the bottom in order
   function automatic void clear_model(input map_t in, output map_t out, output int k);
      int w;
      out = '0;
      k   = 0;
      w   = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (row_is_full(in, r)) k++;
         else begin
            out[w] = in[r];
            w--;
         end
      end
   endfunction

   bit   m_init = 1'b0;
   int   m_cyc  = 0;     // 0 idle, else cycle number within the pass
   int   m_d    = 0;     // cycle number of the done pulse
   int   m_k    = 0;
   map_t m_res  = '0;
   map_t m_out  = '0;
   int   m_lp   = 0;
   int   m_lt   = 0;

   always @(posedge Clk) begin
      if (Reset) begin
         m_init = 1'b1;
         m_cyc  = 0;
         m_d    = 0;
         m_out  = '0;
         m_lp   = 0;
         m_lt   = 0;
      end else if (m_init) begin
         if (m_cyc == 0) begin
            if (bus.start) begin
               m_cyc = 1;
               m_d   = 0;
            end
         end else if (m_cyc == 1) begin
            clear_model(bus.PixelMapIn, m_res, m_k);
            m_d   = ROWS + 2 + 2 * m_k;
            m_cyc = 2;
         end else if (m_cyc == m_d) begin
            m_cyc = 0;
         end else begin
            m_cyc++;
         end
         if (m_cyc >= 2 && m_cyc == m_d) begin
            m_out = m_res;
            m_lp  = (m_k > 7) ? 7 : m_k;
            m_lt  = (m_lt + m_k > 65535) ? 65535 : m_lt + m_k;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge Clk) begin
      if (m_init) begin
         chk("busy", 32'(bus.busy), 32'(m_cyc != 0));
         chk("done", 32'(bus.done), 32'(m_cyc >= 2 && m_cyc == m_d));
         if (m_cyc == 0 || (m_cyc >= 2 && m_cyc == m_d)) begin
            chk_map("map_out", bus.PixelMapOut, m_out);
            chk("lines_pass", 32'(bus.lines_pass), 32'(m_lp));
            chk("lines_total", 32'(bus.lines_total), 32'(m_lt));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic map_t rand_map();
      map_t m;
      int   pct;
      int   sel;
      sel = int'($urandom_range(0, 4));
      case (sel)
         0:       pct = 0;
         1:       pct = 30;
         2:       pct = 60;
         3:       pct = 90;
         default: pct = 100;
      endcase
      for (int r = 0; r < ROWS; r++) begin
         bit full;
         full = (int'($urandom_range(0, 99)) < pct);
         for (int c = 0; c < COLS; c++) begin
            if (!full && $urandom_range(0, 3) == 0) m[r][c] = '0;
            else m[r][c] = CW'($urandom_range(1, (1 << CW) - 1));
         end
      end
      return m;
   endfunction

   task automatic do_reset();
      Reset     = 1'b1;
      bus.start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   // Pulse start (cycle 0) and report the cycle of done plus outputs there
   task automatic run_pass(input map_t m, output int dcyc, output map_t out,
                           output int lp, output int lt);
      bus.PixelMapIn = m;
      bus.start      = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      dcyc      = 1;
      while (bus.done !== 1'b1 && dcyc < 200) begin
         @(negedge Clk);
         dcyc++;
      end
      if (bus.done !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: no done within %0d cycles", dcyc);
      end
      out = bus.PixelMapOut;
      lp  = int'(bus.lines_pass);
      lt  = int'(bus.lines_total);
      @(negedge Clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      map_t m, exp, m28, e28, got;
      int   dcyc, lp, lt, ndone;

      bus.start      = 1'b0;
      bus.PixelMapIn = '0;
      do_reset();

      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_total", 32'(bus.lines_total), 32'd0);

      // Empty board
      run_pass('0, dcyc, got, lp, lt);
      chk("empty_cycle", 32'(dcyc), 32'd22);
      chk("empty_lp", 32'(lp), 32'd0);
      chk("empty_lt", 32'(lt), 32'd0);
      chk_map("empty_map", got, '0);

      // One full bottom row with a single cell above it
      m28 = '0;
      for (int c = 0; c < COLS; c++) m28[19][c] = 4'd3;
      m28[18][0] = 4'd5;
      e28 = '0;
      e28[19][0] = 4'd5;
      run_pass(m28, dcyc, got, lp, lt);
      chk("single_cycle", 32'(dcyc), 32'd24);
      chk("single_lp", 32'(lp), 32'd1);
      chk("single_lt", 32'(lt), 32'd1);
      chk_map("single_map", got, e28);

      // Tetris: four stacked full rows
      do_reset();
      m = '0;
      for (int r = 16; r < 20; r++)
         for (int c = 0; c < COLS; c++) m[r][c] = 4'd1;
      m[15][9] = 4'd2;
      exp = '0;
      exp[19][9] = 4'd2;
      run_pass(m, dcyc, got, lp, lt);
      chk("tetris_cycle", 32'(dcyc), 32'd30);
      chk("tetris_lp", 32'(lp), 32'd4);
      chk("tetris_lt", 32'(lt), 32'd4);
      chk_map("tetris_map", got, exp);
      run_pass(exp, dcyc, got, lp, lt);
      chk("repeat_cycle", 32'(dcyc), 32'd22);
      chk("repeat_lp", 32'(lp), 32'd0);
      chk("repeat_lt", 32'(lt), 32'd4);
      chk_map("repeat_map", got, exp);

      // Whole board full: pass count saturates at 7
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m[r][c] = CW'((r % 15) + 1);
      run_pass(m, dcyc, got, lp, lt);
      chk("allfull_cycle", 32'(dcyc), 32'd62);
      chk("allfull_lp", 32'(lp), 32'd7);
      chk("allfull_lt", 32'(lt), 32'd24);
      chk_map("allfull_map", got, '0);

      // Non-adjacent full rows 19 and 17
      m = '0;
      for (int c = 0; c < COLS; c++) begin
         m[19][c] = 4'd7;
         m[17][c] = 4'd8;
         m[18][c] = (c == 4) ? 4'd0 : 4'd6;
      end
      m[16][2] = 4'd9;
      m[0][0]  = 4'd1;
      exp = '0;
      exp[19]    = m[18];
      exp[18][2] = 4'd9;
      exp[2][0]  = 4'd1;
      run_pass(m, dcyc, got, lp, lt);
      chk("gap_cycle", 32'(dcyc), 32'd26);
      chk("gap_lp", 32'(lp), 32'd2);
      chk("gap_lt", 32'(lt), 32'd26);
      chk_map("gap_map", got, exp);

      // Reset in cycle 10 of a pass
      bus.PixelMapIn = m28;
      bus.start      = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      for (int i = 1; i < 10; i++) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_lt", 32'(bus.lines_total), 32'd0);
      chk_map("midrst_map", bus.PixelMapOut, '0);
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.done === 1'b1) ndone++;
         @(negedge Clk);
      end
      chk("midrst_nodone", 32'(ndone), 32'd0);
      run_pass(m28, dcyc, got, lp, lt);
      chk("afterrst_cycle", 32'(dcyc), 32'd24);
      chk("afterrst_lt", 32'(lt), 32'd1);
      chk_map("afterrst_map", got, e28);

      // Re-pulsed start and a changing snapshot during the pass
      bus.PixelMapIn = m28;
      bus.start      = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      ndone     = 0;
      got       = '0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (cyc == 3) bus.PixelMapIn = rand_map();
         bus.start = (cyc == 5 || cyc == 12);
         if (bus.done === 1'b1) begin
            ndone++;
            got = bus.PixelMapOut;
         end
         @(negedge Clk);
      end
      bus.start = 1'b0;
      chk("restart_ndone", 32'(ndone), 32'd1);
      chk_map("restart_map", got, e28);
      chk("restart_lt", 32'(bus.lines_total), 32'd2);

      // Random traffic with occasional resets
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bus.start = ($urandom_range(0, 7) == 0);
         Reset     = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 2) == 0) bus.PixelMapIn = rand_map();
         @(negedge Clk);
      end
      bus.start = 1'b0;
      Reset     = 1'b0;
      for (int i = 0; i < 80; i++) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
